// File: rtl/jtopl_wrseq_if.sv
// Request/bus bundle between a host front end and the OPL write sequencer.
// The host side (master) drives requests and the chip clock enable, and the
// sequencer side (slave) returns flow control, status and the jtopl_mmr bus.
interface jtopl_wrseq_if;
  logic       cen;
  logic       req_valid;
  logic [7:0] req_reg;
  logic [7:0] req_val;
  logic       req_ready;
  logic       busy;
  logic       write;
  logic       addr;
  logic [7:0] dout;
  logic       ovf;

  modport master (
    output cen, req_valid, req_reg, req_val,
    input  req_ready, busy, write, addr, dout, ovf
  );

  modport slave (
    input  cen, req_valid, req_reg, req_val,
    output req_ready, busy, write, addr, dout, ovf
  );
endinterface

// File: rtl/jtopl_wrseq.sv
// OPL register-port write sequencer.
// Queues {register, value} requests and replays each as an address-phase
// write (addr=0) followed by a data-phase write (addr=1). The guard waits
// after each phase are counted in cen ticks. When SKIP_SAME is set, the
// address phase is skipped if the register is already latched in the chip.
module jtopl_wrseq #(
  parameter int AW        = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84,
  parameter int SKIP_SAME = 1
) (
  input  logic          clk,
  input  logic          rst,
  jtopl_wrseq_if.slave  bus
);

  localparam int DEPTH = 1 << AW;
  localparam int MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW    = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    AWAIT = 3'd2,
    DATA  = 3'd3,
    DWAIT = 3'd4
  } state_t;

  logic [15:0]   fifo_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    last_reg_q, last_reg_d;
  logic          last_ok_q, last_ok_d;
  logic          write_q, write_d;
  logic          addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          ovf_q, ovf_d;

  logic          full, empty, pop, push, ready;
  logic [7:0]    head_reg, head_val;

  assign head_reg = fifo_q[rptr_q][15:8];
  assign head_val = fifo_q[rptr_q][7:0];

  // FIFO status and handshake; a pop in IDLE frees a slot in the same clk,
  // so a full FIFO still accepts the push that coincides with the pop.
  always_comb begin
    full  = (occ_q == (AW+1)'(DEPTH));
    empty = (occ_q == '0);
    pop   = (state_q == IDLE) && !empty;
    ready = !full || pop;
    push  = bus.req_valid && ready;
  end

  // Next-state logic for FIFO pointers, sequencer FSM and registered bus outputs.
  always_comb begin
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;
    occ_d      = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    ovf_d      = ovf_q | (bus.req_valid & ~ready);
    state_d    = state_q;
    cnt_d      = cnt_q;
    reg_d      = reg_q;
    val_d      = val_q;
    last_reg_d = last_reg_q;
    last_ok_d  = last_ok_q;
    write_d    = 1'b0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          reg_d = head_reg;
          val_d = head_val;
          if ((SKIP_SAME != 0) && last_ok_q && (head_reg == last_reg_q)) begin
            state_d = DATA;
            write_d = 1'b1;
            addr_d  = 1'b1;
            dout_d  = head_val;
          end else begin
            state_d = ADDR;
            write_d = 1'b1;
            addr_d  = 1'b0;
            dout_d  = head_reg;
          end
        end
      end
      ADDR: begin
        last_reg_d = reg_q;
        last_ok_d  = 1'b1;
        cnt_d      = CW'(ADDR_WAIT);
        state_d    = AWAIT;
      end
      AWAIT: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          write_d = 1'b1;
          addr_d  = 1'b1;
          dout_d  = val_q;
        end else if (bus.cen) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        cnt_d   = CW'(DATA_WAIT);
        state_d = DWAIT;
      end
      DWAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (bus.cen) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and bus outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_ok_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_ok_q <= last_ok_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
    end
  end

  // Request payload registers; only meaningful while guarded by the FSM/last_ok.
  always_ff @(posedge clk) begin
    reg_q      <= reg_d;
    val_q      <= val_d;
    last_reg_q <= last_reg_d;
  end

  // FIFO storage; entries are written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {bus.req_reg, bus.req_val};
  end

  assign bus.req_ready = ready;
  assign bus.busy      = !empty || (state_q != IDLE);
  assign bus.write     = write_q;
  assign bus.addr      = addr_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

endmodule
